// File: rtl/i2s_sample_receiver.sv
// i2s_sample_receiver
// Recovers signed PCM words from an I2S stream (MSB first, one-bit delay after
// every LR transition, lrck=0 left / lrck=1 right). Everything runs on the
// oversampling system clock, which must be at least 8x the bit clock.
// Optional build macro: I2S_RX_STEREO_PAIR_EN. When it is defined, left words are
// staged internally and both channels are presented together once per frame.
module i2s_sample_receiver #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i2s_sclk,
    input  logic                    i2s_lrck,
    input  logic                    i2s_sdata,
    output logic [SAMPLE_WIDTH-1:0] sample_left,
    output logic [SAMPLE_WIDTH-1:0] sample_right,
    output logic                    sample_ch,
    output logic                    sample_valid,
    output logic                    frame_err,
    input  logic                    clear_err
);

    localparam int CW = $clog2(SAMPLE_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, DELAY, SHIFT, DONE} state_t;

    logic [SYNC_STAGES-1:0]  sclkSync_q, lrckSync_q, sdataSync_q;
    logic                    sclkPrev_q, riseEvt_q, lrckEvt_q, sdataEvt_q;
    state_t                  state_q;
    logic                    primed_q, lrckPrev_q, chan_q;
    logic [SAMPLE_WIDTH-1:0] shiftReg_q;
    logic [CW-1:0]           cnt_q;
    logic                    commit_q, commitCh_q;
    logic [SAMPLE_WIDTH-1:0] commitWord_q;
    logic [SAMPLE_WIDTH-1:0] sampleLeft_q, sampleRight_q;
    logic                    sampleCh_q, sampleValid_q;
    logic                    frameErr_q, frameErr_d;

    logic                    lrckChg, shortErr, pairErr;
    logic [SAMPLE_WIDTH-1:0] shiftNext, shortWord;

    assign lrckChg   = lrckEvt_q != lrckPrev_q;
    assign shiftNext = {shiftReg_q[SAMPLE_WIDTH-2:0], sdataEvt_q};
    // A slot cut short keeps its bits MSB-aligned and zero fills the tail.
    assign shortWord = shiftReg_q << (CW'(SAMPLE_WIDTH) - cnt_q);
    assign shortErr  = riseEvt_q && (state_q == SHIFT) && lrckChg;

    // Bring the three asynchronous serial lines into the clk domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclkSync_q  <= '0;
            lrckSync_q  <= '0;
            sdataSync_q <= '0;
        end else begin
            sclkSync_q  <= {sclkSync_q[SYNC_STAGES-2:0], i2s_sclk};
            lrckSync_q  <= {lrckSync_q[SYNC_STAGES-2:0], i2s_lrck};
            sdataSync_q <= {sdataSync_q[SYNC_STAGES-2:0], i2s_sdata};
        end
    end

    // Register an sclk rise event together with the lrck/sdata seen at that same stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclkPrev_q <= 1'b0;
            riseEvt_q  <= 1'b0;
            lrckEvt_q  <= 1'b0;
            sdataEvt_q <= 1'b0;
        end else begin
            sclkPrev_q <= sclkSync_q[SYNC_STAGES-1];
            riseEvt_q  <= sclkSync_q[SYNC_STAGES-1] & ~sclkPrev_q;
            lrckEvt_q  <= lrckSync_q[SYNC_STAGES-1];
            sdataEvt_q <= sdataSync_q[SYNC_STAGES-1];
        end
    end

    // Slot framing FSM; the bit that reveals an LR change is the delay bit, so
    // DELAY only lasts one clk to clear the word before the MSB arrives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            primed_q     <= 1'b0;
            lrckPrev_q   <= 1'b0;
            chan_q       <= 1'b0;
            shiftReg_q   <= '0;
            cnt_q        <= '0;
            commit_q     <= 1'b0;
            commitCh_q   <= 1'b0;
            commitWord_q <= '0;
        end else begin
            commit_q <= 1'b0;
            if (riseEvt_q) begin
                lrckPrev_q <= lrckEvt_q;
            end
            case (state_q)
                IDLE: begin
                    if (riseEvt_q) begin
                        primed_q <= 1'b1;
                        if (primed_q && lrckChg) begin
                            chan_q  <= ~lrckPrev_q;
                            state_q <= DELAY;
                        end
                    end
                end
                DELAY: begin
                    shiftReg_q <= '0;
                    cnt_q      <= '0;
                    state_q    <= SHIFT;
                end
                SHIFT: begin
                    if (riseEvt_q) begin
                        if (lrckChg) begin
                            commit_q     <= 1'b1;
                            commitCh_q   <= chan_q;
                            commitWord_q <= shortWord;
                            chan_q       <= ~lrckPrev_q;
                            state_q      <= DELAY;
                        end else begin
                            shiftReg_q <= shiftNext;
                            cnt_q      <= cnt_q + CW'(1);
                            if (cnt_q == CW'(SAMPLE_WIDTH - 1)) begin
                                commit_q     <= 1'b1;
                                commitCh_q   <= chan_q;
                                commitWord_q <= shiftNext;
                                state_q      <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    if (riseEvt_q && lrckChg) begin
                        chan_q  <= ~lrckPrev_q;
                        state_q <= DELAY;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef I2S_RX_STEREO_PAIR_EN
    logic [SAMPLE_WIDTH-1:0] leftStage_q;
    logic                    staged_q;

    assign pairErr = commit_q && commitCh_q && !staged_q;

    // Hold left words until the matching right word arrives, then present the pair.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            leftStage_q   <= '0;
            staged_q      <= 1'b0;
            sampleLeft_q  <= '0;
            sampleRight_q <= '0;
            sampleCh_q    <= 1'b0;
            sampleValid_q <= 1'b0;
        end else begin
            sampleValid_q <= 1'b0;
            if (commit_q) begin
                if (!commitCh_q) begin
                    leftStage_q <= commitWord_q;
                    staged_q    <= 1'b1;
                end else begin
                    sampleLeft_q  <= staged_q ? leftStage_q : '0;
                    sampleRight_q <= commitWord_q;
                    sampleCh_q    <= 1'b1;
                    sampleValid_q <= 1'b1;
                    staged_q      <= 1'b0;
                end
            end
        end
    end
`else
    assign pairErr = 1'b0;

    // Each committed word updates only its own channel register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sampleLeft_q  <= '0;
            sampleRight_q <= '0;
            sampleCh_q    <= 1'b0;
            sampleValid_q <= 1'b0;
        end else begin
            sampleValid_q <= 1'b0;
            if (commit_q) begin
                if (commitCh_q) begin
                    sampleRight_q <= commitWord_q;
                end else begin
                    sampleLeft_q <= commitWord_q;
                end
                sampleCh_q    <= commitCh_q;
                sampleValid_q <= 1'b1;
            end
        end
    end
`endif

    // A new error always beats a simultaneous clear.
    always_comb begin
        frameErr_d = frameErr_q;
        if (shortErr || pairErr) begin
            frameErr_d = 1'b1;
        end else if (clear_err) begin
            frameErr_d = 1'b0;
        end
    end

    // Sticky framing error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frameErr_q <= 1'b0;
        end else begin
            frameErr_q <= frameErr_d;
        end
    end

    assign sample_left  = sampleLeft_q;
    assign sample_right = sampleRight_q;
    assign sample_ch    = sampleCh_q;
    assign sample_valid = sampleValid_q;
    assign frame_err    = frameErr_q;

endmodule
